// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared pipeline register package: controller states and defaults
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } pipe_state_t;

    localparam int MEM_WAIT_MAX_DEFAULT = 15;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// rtl/pipe_ctrl_hazard_detect.sv - load-use hazard compare between ID/EX and IF/ID
module hazard_detect (
    input  logic       mem_read,
    input  logic [4:0] rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    output logic       hazard
);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign hazard = mem_read && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller; PIPE_CTRL_PERF_EN adds performance counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        idex_mem_read,
    input  logic [4:0]  idex_rd,
    input  logic [4:0]  ifid_rs1,
    input  logic [4:0]  ifid_rs2,
    input  logic        exmem_branch_taken,
    input  logic        exmem_mem_req,
    input  logic        dmem_ack,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic        pc_sel_branch,
    output logic [1:0]  state,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] bubble_cnt,
`endif
    output logic        mem_timeout
);

    localparam logic [7:0] WAIT_MAX = MEM_WAIT_MAX[7:0];

    pipe_state_t cur_state;
    logic [7:0]  wait_cnt;
    logic        hazard;
    logic        is_stall;
    logic        is_flush;
    logic        is_bubble;
    logic        frozen;

    hazard_detect u_hazard (
        .mem_read (idex_mem_read),
        .rd       (idex_rd),
        .rs1      (ifid_rs1),
        .rs2      (ifid_rs2),
        .hazard   (hazard)
    );

    // Priority: memory stall, then branch flush, then load-use bubble.
    always_comb begin
        is_stall  = 1'b0;
        is_flush  = 1'b0;
        is_bubble = 1'b0;
        frozen    = 1'b0;
        case (cur_state)
            ST_RUN:      is_stall = exmem_mem_req && !dmem_ack;
            ST_MEM_WAIT: is_stall = !dmem_ack;
            default:     frozen   = 1'b1;
        endcase
        if (!frozen && !is_stall) begin
            is_flush  = exmem_branch_taken;
            is_bubble = !exmem_branch_taken && hazard;
        end
        if (!rst_n) begin
            is_stall  = 1'b0;
            is_flush  = 1'b0;
            is_bubble = 1'b0;
        end
    end

    assign pc_en         = rst_n && !frozen && !is_stall && !is_bubble;
    assign ifid_en       = rst_n && !frozen && !is_stall && !is_bubble;
    assign idex_en       = rst_n && !frozen && !is_stall;
    assign exmem_en      = rst_n && !frozen && !is_stall;
    assign memwb_en      = rst_n && !frozen;
    assign ifid_flush    = !rst_n || is_flush;
    assign idex_flush    = !rst_n || is_flush || is_bubble;
    assign exmem_flush   = !rst_n || is_flush;
    assign memwb_flush   = !rst_n || is_stall;
    assign pc_sel_branch = is_flush;
    assign state         = cur_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state   <= ST_RUN;
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
        end else begin
            case (cur_state)
                ST_RUN: begin
                    if (exmem_mem_req && !dmem_ack) begin
                        cur_state <= ST_MEM_WAIT;
                        wait_cnt  <= 8'd1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_ack) begin
                        cur_state <= ST_RUN;
                        wait_cnt  <= 8'd0;
                    end else if (wait_cnt >= WAIT_MAX) begin
                        cur_state   <= ST_HALT;
                        wait_cnt    <= 8'd0;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_HALT: begin
                    cur_state <= ST_HALT;
                    wait_cnt  <= 8'd0;
                end
                default: begin
                    cur_state <= ST_RUN;
                    wait_cnt  <= 8'd0;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= 32'd0;
            flush_cnt  <= 32'd0;
            bubble_cnt <= 32'd0;
        end else begin
            if (is_stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;
            if (is_flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 32'd1;
            if (is_bubble && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MEM_WAIT_MAX, default 15: maximum data-memory wait cycles before a timeout is declared (legal range 1..255).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 idex_mem_read  input  1  MemRead held in the ID/EX register.
REQ-005 idex_rd  input  5  WriteRegister held in the ID/EX register.
REQ-006 ifid_rs1, ifid_rs2  input  5 each  source register addresses decoded from the IF/ID instruction.
REQ-007 exmem_branch_taken  input  1  resolved taken branch in the EX/MEM register.
REQ-008 exmem_mem_req  input  1  EX/MEM MemRead or MemWrite.
REQ-009 dmem_ack  input  1  data-memory completion for the current request.
REQ-010 pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1 each  load enables for the PC and the four pipeline registers.
REQ-011 ifid_flush, idex_flush, exmem_flush, memwb_flush  output  1 each  load a bubble (all control bits 0) into that register.
REQ-012 pc_sel_branch  output  1  selects the branch target (PC_Imme) as the next PC.
REQ-013 state  output  2  current controller state.
REQ-014 mem_timeout  output  1  sticky error flag.

Function
REQ-015 States SHALL be RUN=0, MEM_WAIT=1, HALT=2; encoding 3 is unreachable and SHALL recover to RUN on the next edge.
REQ-016 All enable, flush and select outputs SHALL be combinational from state and inputs, with zero-cycle latency.
REQ-017 Load-use hazard = idex_mem_read && idex_rd!=0 && (idex_rd==ifid_rs1 || idex_rd==ifid_rs2).
REQ-018 RUN, no event: all enables 1, all flushes 0, pc_sel_branch 0.
REQ-019 RUN, load-use only: pc_en=0, ifid_en=0, idex_flush=1, remaining enables 1; exactly one bubble per hazard cycle.
REQ-020 RUN, branch taken with no memory stall: pc_sel_branch=1, ifid_flush=idex_flush=exmem_flush=1, all enables 1; any coincident load-use SHALL be ignored.
REQ-021 RUN, exmem_mem_req && !dmem_ack: pc_en, ifid_en, idex_en and exmem_en=0; memwb_flush=1; next state MEM_WAIT; wait counter loads 1.
REQ-022 RUN, exmem_mem_req && dmem_ack in the same cycle: no stall; the priorities of REQ-019 and REQ-020 apply.
REQ-023 MEM_WAIT: outputs as in REQ-021 while !dmem_ack; the counter increments each cycle.
REQ-024 MEM_WAIT with dmem_ack: next state RUN. That cycle's outputs follow the RUN rules, so a pending branch or load-use is serviced in the ack cycle.
REQ-025 MEM_WAIT with counter==MEM_WAIT_MAX and !dmem_ack: next state HALT and mem_timeout set; dmem_ack in the same cycle SHALL win.
REQ-026 Priority SHALL be memory stall > branch flush > load-use.
REQ-027 HALT: all enables 0, all flushes 0, pc_sel_branch 0; remain in HALT until reset.
REQ-028 The wait counter SHALL be 8 bits, SHALL reset to 0 on leaving MEM_WAIT, and SHALL never wrap.

Reset
REQ-029 rst_n low SHALL immediately force state=RUN, counter=0 and mem_timeout=0.
REQ-030 While rst_n is low: all enables 0, all four flushes 1, pc_sel_branch 0.
REQ-031 Reset asserted mid-MEM_WAIT or in HALT SHALL abandon the operation with no residual state.

Configuration
REQ-032 With PIPE_CTRL_PERF_EN defined, the block SHALL add outputs stall_cnt (32), flush_cnt (32) and bubble_cnt (32).
REQ-033 stall_cnt counts memory-stall cycles, flush_cnt counts branch flushes and bubble_cnt counts load-use bubbles; all three saturate at all-ones and clear on reset.
REQ-034 Without PIPE_CTRL_PERF_EN, these ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-035 The state enum (pipe_state_t) and the constant MEM_WAIT_MAX_DEFAULT SHALL live in the shared pipeline register package.
REQ-036 The combinational load-use compare of REQ-017 SHALL be a sub-module, hazard_detect.

Verification
REQ-037 idex_mem_read=1, idex_rd=5, ifid_rs2=5 in RUN -> pc_en=0, ifid_en=0, idex_flush=1 for 1 cycle; idex_rd=0 with rs1=0 -> no stall.
REQ-038 exmem_branch_taken=1 in RUN with a coincident load-use -> pc_sel_branch=1, three flushes=1, pc_en=1 (no stall).
REQ-039 exmem_mem_req=1, dmem_ack rises after 3 cycles -> state=1 for 3 cycles, memwb_flush=1 throughout, state=0 in the ack cycle.
REQ-040 MEM_WAIT_MAX=4, no ack -> state=2 and mem_timeout=1 after the 4th wait cycle; all enables 0; rst_n pulse -> state=0, mem_timeout=0.
REQ-041 Branch taken during MEM_WAIT -> no flush until ack; flush outputs assert in the ack cycle.
REQ-042 PIPE_CTRL_PERF_EN defined, 2 bubbles + 1 flush + 3 stall cycles -> bubble_cnt=2, flush_cnt=1, stall_cnt=3.
